operand_collector: RTL and testbench

//   Issue-side producer for the warp-wide integer ALU. Accepts one decoded

---
 rtl/operand_collector.sv | 220 ++++++++++++++++++++++
 tb/tb_operand_collector.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_collector.sv
// operand_collector
//   Issue-side operand gatherer for the warp-wide integer ALU. It accepts one
//   decoded instruction at a time and reads its 0..3 source registers, one per
//   cycle, through a single register-file read port. The assembled bundle is
//   then offered to the ALU with a valid/ready handshake.
//
// Ports
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_iss_*  / o_iss_ready      instruction issue handshake and fields
//   o_rf_rd_en/warp/idx         register-file read request
//   i_rf_rd_data                read data, valid one cycle after o_rf_rd_en
//   o_alu_valid / i_alu_ready   bundle handshake towards the ALU
//   o_alu_op/warp/imm/rd/pred   latched pass-through fields
//   o_alu_rs1/rs2/rs3           collected operands (unfetched slots are 0)
//   o_busy                      collector is not idle
//
// state    | meaning
// S_IDLE   | waiting for an instruction, o_iss_ready=1
// S_READ   | one source read issued per cycle, previous read captured
// S_DRAIN  | no read issued, last read's data captured
// S_DISPATCH | bundle presented to the ALU until accepted
module operand_collector #(
  parameter int WARP_SIZE = 32,
  parameter int NUM_REGS  = 64,
  localparam int RIDX_W   = $clog2(NUM_REGS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_iss_valid,
  output logic                    o_iss_ready,
  input  logic [7:0]              i_iss_op,
  input  logic [4:0]              i_iss_warp,
  input  logic [31:0]             i_iss_imm,
  input  logic [1:0]              i_iss_nsrc,
  input  logic [RIDX_W-1:0]       i_iss_rs1,
  input  logic [RIDX_W-1:0]       i_iss_rs2,
  input  logic [RIDX_W-1:0]       i_iss_rs3,
  input  logic [RIDX_W-1:0]       i_iss_rd,
  input  logic [WARP_SIZE-1:0]    i_iss_pred,
  output logic                    o_rf_rd_en,
  output logic [4:0]              o_rf_rd_warp,
  output logic [RIDX_W-1:0]       o_rf_rd_idx,
  input  logic [WARP_SIZE*32-1:0] i_rf_rd_data,
  output logic                    o_alu_valid,
  input  logic                    i_alu_ready,
  output logic [7:0]              o_alu_op,
  output logic [4:0]              o_alu_warp,
  output logic [31:0]             o_alu_imm,
  output logic [RIDX_W-1:0]       o_alu_rd,
  output logic [WARP_SIZE-1:0]    o_alu_pred,
  output logic [WARP_SIZE*32-1:0] o_alu_rs1,
  output logic [WARP_SIZE*32-1:0] o_alu_rs2,
  output logic [WARP_SIZE*32-1:0] o_alu_rs3,
  output logic                    o_busy
);

  localparam int DW = WARP_SIZE * 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DISPATCH
  } state_t;

  state_t              r_state;
  logic                r_iss_ready;
  logic                r_rf_rd_en;
  logic [RIDX_W-1:0]   r_rf_rd_idx;
  logic                r_alu_valid;

  logic [7:0]          r_op;
  logic [4:0]          r_warp;
  logic [31:0]         r_imm;
  logic [1:0]          r_nsrc;
  logic [RIDX_W-1:0]   r_rs1;
  logic [RIDX_W-1:0]   r_rs2;
  logic [RIDX_W-1:0]   r_rs3;
  logic [RIDX_W-1:0]   r_rd;
  logic [WARP_SIZE-1:0] r_pred;
  logic [DW-1:0]       r_opnd1;
  logic [DW-1:0]       r_opnd2;
  logic [DW-1:0]       r_opnd3;

  // Slot of the read currently on the port, and the slot whose data arrives
  // this cycle (the read port has one cycle of latency).
  logic [1:0]          r_rd_slot;
  logic                r_cap_valid;
  logic [1:0]          r_cap_slot;

  logic [2:0]          w_next_slot;
  logic                w_more;
  logic [RIDX_W-1:0]   w_next_idx;

  assign w_next_slot = {1'b0, r_rd_slot} + 3'd1;
  assign w_more      = (w_next_slot < {1'b0, r_nsrc});

  always_comb begin
    w_next_idx = r_rs1;
    case (w_next_slot[1:0])
      2'd1:    w_next_idx = r_rs2;
      2'd2:    w_next_idx = r_rs3;
      default: w_next_idx = r_rs1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_iss_ready <= 1'b1;
      r_rf_rd_en  <= 1'b0;
      r_rf_rd_idx <= '0;
      r_alu_valid <= 1'b0;
      r_op        <= '0;
      r_warp      <= '0;
      r_imm       <= '0;
      r_nsrc      <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs3       <= '0;
      r_rd        <= '0;
      r_pred      <= '0;
      r_opnd1     <= '0;
      r_opnd2     <= '0;
      r_opnd3     <= '0;
      r_rd_slot   <= '0;
      r_cap_valid <= 1'b0;
      r_cap_slot  <= '0;
    end else begin
      r_cap_valid <= 1'b0;

      if (r_cap_valid) begin
        case (r_cap_slot)
          2'd0:    r_opnd1 <= i_rf_rd_data;
          2'd1:    r_opnd2 <= i_rf_rd_data;
          default: r_opnd3 <= i_rf_rd_data;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (i_iss_valid) begin
            r_op        <= i_iss_op;
            r_warp      <= i_iss_warp;
            r_imm       <= i_iss_imm;
            r_nsrc      <= i_iss_nsrc;
            r_rs1       <= i_iss_rs1;
            r_rs2       <= i_iss_rs2;
            r_rs3       <= i_iss_rs3;
            r_rd        <= i_iss_rd;
            r_pred      <= i_iss_pred;
            r_opnd1     <= '0;
            r_opnd2     <= '0;
            r_opnd3     <= '0;
            r_iss_ready <= 1'b0;
            r_rd_slot   <= '0;
            if (i_iss_nsrc == 2'd0) begin
              r_state     <= S_DISPATCH;
              r_alu_valid <= 1'b1;
            end else begin
              r_state     <= S_READ;
              r_rf_rd_en  <= 1'b1;
              r_rf_rd_idx <= i_iss_rs1;
            end
          end
        end

        S_READ: begin
          // The read on the port now lands next cycle.
          r_cap_valid <= 1'b1;
          r_cap_slot  <= r_rd_slot;
          if (w_more) begin
            r_rd_slot   <= w_next_slot[1:0];
            r_rf_rd_idx <= w_next_idx;
          end else begin
            r_state     <= S_DRAIN;
            r_rf_rd_en  <= 1'b0;
            r_rf_rd_idx <= '0;
          end
        end

        S_DRAIN: begin
          r_state     <= S_DISPATCH;
          r_alu_valid <= 1'b1;
        end

        S_DISPATCH: begin
          if (i_alu_ready) begin
            r_state     <= S_IDLE;
            r_alu_valid <= 1'b0;
            r_iss_ready <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_iss_ready <= 1'b1;
          r_rf_rd_en  <= 1'b0;
          r_alu_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_iss_ready  = r_iss_ready;
  assign o_rf_rd_en   = r_rf_rd_en;
  assign o_rf_rd_warp = r_warp;
  assign o_rf_rd_idx  = r_rf_rd_idx;
  assign o_alu_valid  = r_alu_valid;
  assign o_alu_op     = r_op;
  assign o_alu_warp   = r_warp;
  assign o_alu_imm    = r_imm;
  assign o_alu_rd     = r_rd;
  assign o_alu_pred   = r_pred;
  assign o_alu_rs1    = r_opnd1;
  assign o_alu_rs2    = r_opnd2;
  assign o_alu_rs3    = r_opnd3;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_operand_collector.sv
module tb_operand_collector;
  localparam int WS = 32;
  localparam int NR = 64;
  localparam int RW = 6;
  localparam int DW = WS * 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_valid;
  logic          iss_ready;
  logic [7:0]    iss_op;
  logic [4:0]    iss_warp;
  logic [31:0]   iss_imm;
  logic [1:0]    iss_nsrc;
  logic [RW-1:0] iss_rs1, iss_rs2, iss_rs3, iss_rd;
  logic [WS-1:0] iss_pred;
  logic          rf_rd_en;
  logic [4:0]    rf_rd_warp;
  logic [RW-1:0] rf_rd_idx;
  logic [DW-1:0] rf_rd_data;
  logic          alu_valid;
  logic          alu_ready;
  logic [7:0]    alu_op;
  logic [4:0]    alu_warp;
  logic [31:0]   alu_imm;
  logic [RW-1:0] alu_rd;
  logic [WS-1:0] alu_pred;
  logic [DW-1:0] alu_rs1, alu_rs2, alu_rs3;
  logic          busy;

  always #5 clk = ~clk;

  operand_collector #(.WARP_SIZE(WS), .NUM_REGS(NR)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_iss_valid(iss_valid), .o_iss_ready(iss_ready),
    .i_iss_op(iss_op), .i_iss_warp(iss_warp), .i_iss_imm(iss_imm),
    .i_iss_nsrc(iss_nsrc), .i_iss_rs1(iss_rs1), .i_iss_rs2(iss_rs2),
    .i_iss_rs3(iss_rs3), .i_iss_rd(iss_rd), .i_iss_pred(iss_pred),
    .o_rf_rd_en(rf_rd_en), .o_rf_rd_warp(rf_rd_warp), .o_rf_rd_idx(rf_rd_idx),
    .i_rf_rd_data(rf_rd_data),
    .o_alu_valid(alu_valid), .i_alu_ready(alu_ready),
    .o_alu_op(alu_op), .o_alu_warp(alu_warp), .o_alu_imm(alu_imm),
    .o_alu_rd(alu_rd), .o_alu_pred(alu_pred),
    .o_alu_rs1(alu_rs1), .o_alu_rs2(alu_rs2), .o_alu_rs3(alu_rs3),
    .o_busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rf_seed = 0;

  // Read-port log, filled from the outside of the design.
  int rd_cyc[$];
  int rd_idx[$];
  int rd_warp[$];

  // Reference description of the instruction in flight.
  logic [7:0]    e_op;
  logic [4:0]    e_warp;
  logic [31:0]   e_imm;
  int            e_nsrc;
  int            e_rs[3];
  logic [RW-1:0] e_rd;
  logic [WS-1:0] e_pred;
  int            e_seed;
  int            accept_cyc, log_start, waited, rel;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rf_rd_en === 1'b1) begin
      rd_cyc.push_back(cyc);
      rd_idx.push_back(int'(rf_rd_idx));
      rd_warp.push_back(int'(rf_rd_warp));
    end
  end

  function automatic logic [31:0] rf_val(int seed, int warp, int idx, int lane);
    return 32'(seed + warp * 7000 + idx * 100 + lane);
  endfunction

  // Register file: answers a read one cycle later, otherwise drives noise.
  always @(posedge clk) begin
    logic [DW-1:0] d;
    for (int l = 0; l < WS; l++)
      d[l*32 +: 32] = (rf_rd_en === 1'b1) ? rf_val(rf_seed, int'(rf_rd_warp), int'(rf_rd_idx), l)
                                           : $urandom();
    rf_rd_data <= d;
  end

  function automatic logic [31:0] exp_lane(int slot, int lane);
    return (slot < e_nsrc) ? rf_val(e_seed, int'(e_warp), e_rs[slot], lane) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_txn(input logic [7:0] op, input logic [4:0] warp, input logic [31:0] imm,
                         input int nsrc, input int rs1, input int rs2, input int rs3,
                         input int rd, input logic [WS-1:0] pred, input int seed);
    e_op = op; e_warp = warp; e_imm = imm; e_nsrc = nsrc;
    e_rs[0] = rs1; e_rs[1] = rs2; e_rs[2] = rs3;
    e_rd = RW'(rd); e_pred = pred; e_seed = seed; rf_seed = seed;
    iss_op = op; iss_warp = warp; iss_imm = imm; iss_nsrc = 2'(nsrc);
    iss_rs1 = RW'(rs1); iss_rs2 = RW'(rs2); iss_rs3 = RW'(rs3);
    iss_rd = RW'(rd); iss_pred = pred;
  endtask

  // Called at a negedge; leaves the caller at the negedge after the accept edge.
  task automatic do_accept();
    iss_valid = 1'b1;
    waited = 0;
    while (iss_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", iss_ready, 1);
    log_start = rd_cyc.size();
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    rel = 1;
    chk("ready_low_after_accept", iss_ready, 0);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_valid();
    int lat;
    lat = (e_nsrc == 0) ? 1 : e_nsrc + 2;
    while (alu_valid !== 1'b1 && rel < 30) begin
      chk("ready_low_while_busy", iss_ready, 0);
      @(negedge clk);
      rel++;
    end
    chk("valid_latency", rel, lat);
  endtask

  task automatic check_bundle();
    chk("alu_op", alu_op, e_op);
    chk("alu_warp", alu_warp, e_warp);
    chk("alu_imm", alu_imm, e_imm);
    chk("alu_rd", alu_rd, e_rd);
    chk("alu_pred", alu_pred, e_pred);
    for (int l = 0; l < WS; l++) begin
      chk("alu_rs1_lane", alu_rs1[l*32 +: 32], exp_lane(0, l));
      chk("alu_rs2_lane", alu_rs2[l*32 +: 32], exp_lane(1, l));
      chk("alu_rs3_lane", alu_rs3[l*32 +: 32], exp_lane(2, l));
    end
  endtask

  task automatic check_reads();
    int n;
    n = rd_cyc.size() - log_start;
    chk("rd_count", n, e_nsrc);
    for (int i = 0; i < n && i < 3; i++) begin
      chk("rd_idx", rd_idx[log_start + i], e_rs[i]);
      chk("rd_warp", rd_warp[log_start + i], e_warp);
      chk("rd_cycle", rd_cyc[log_start + i] - accept_cyc + 1, i + 1);
    end
  endtask

  task automatic do_handshake();
    alu_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alu_ready = 1'b0;
    chk("valid_low_after_hs", alu_valid, 0);
    chk("ready_after_hs", iss_ready, 1);
    chk("busy_after_hs", busy, 0);
  endtask

  task automatic start_txn();
    do_accept();
    iss_valid = 1'b0;
    wait_valid();
    check_bundle();
    check_reads();
  endtask

  task automatic finish_txn(input int hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", alu_valid, 1);
      chk("hold_ready_low", iss_ready, 0);
      check_bundle();
    end
    do_handshake();
  endtask

  initial begin
    rst = 1'b1;
    iss_valid = 1'b0; alu_ready = 1'b0;
    iss_op = '0; iss_warp = '0; iss_imm = '0; iss_nsrc = '0;
    iss_rs1 = '0; iss_rs2 = '0; iss_rs3 = '0; iss_rd = '0; iss_pred = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_rf_rd_en", rf_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_rs1", alu_rs1[63:0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", iss_ready, 1);

    // nsrc=0: immediate dispatch, no reads.
    set_txn(8'h21, 5'd3, 32'd5, 0, 1, 2, 3, 4, 32'hFFFF_0000, 11);
    start_txn();
    finish_txn(0);

    // nsrc=2 with RF lane value idx*100+lane.
    set_txn(8'h10, 5'd0, 32'd0, 2, 3, 7, 11, 1, 32'hFFFF_FFFF, 0);
    start_txn();
    chk("t2_rs1_lane5", alu_rs1[5*32 +: 32], 305);
    chk("t2_rs2_lane5", alu_rs2[5*32 +: 32], 705);
    chk("t2_rs3_lane5", alu_rs3[5*32 +: 32], 0);
    finish_txn(0);

    // nsrc=3 with ALU backpressure.
    set_txn(8'h33, 5'd17, 32'hDEAD_BEEF, 3, 60, 1, 42, 9, 32'h1234_5678, 500);
    start_txn();
    finish_txn(4);

    // Back-to-back issues with iss_valid held high.
    set_txn(8'hA1, 5'd5, 32'd1, 1, 20, 0, 0, 2, 32'h0000_00FF, 1000);
    do_accept();
    wait_valid();
    check_bundle();
    check_reads();
    set_txn(8'hB2, 5'd9, 32'd2, 2, 30, 31, 0, 3, 32'h0F0F_0F0F, 2000);
    do_handshake();
    do_accept();
    chk("b2b_accept_wait", waited, 0);
    iss_valid = 1'b0;
    wait_valid();
    check_bundle();
    check_reads();
    finish_txn(1);

    // Reset while in DRAIN.
    set_txn(8'h55, 5'd2, 32'd7, 3, 4, 5, 6, 7, 32'hAAAA_5555, 3000);
    do_accept();
    iss_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain_rd_en", rf_rd_en, 0);
    chk("drain_busy", busy, 1);
    chk("drain_no_valid", alu_valid, 0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", alu_valid, 0);
    chk("midrst_ready", iss_ready, 1);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reads();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("postrst_no_valid", alu_valid, 0);
      chk("postrst_idle", busy, 0);
      for (int l = 0; l < WS; l++) begin
        chk("postrst_rs1_zero", alu_rs1[l*32 +: 32], 0);
        chk("postrst_rs3_zero", alu_rs3[l*32 +: 32], 0);
      end
    end

    // Same register read twice.
    set_txn(8'h66, 5'd12, 32'd9, 2, 9, 9, 0, 8, 32'h8000_0001, 4000);
    start_txn();
    for (int l = 0; l < WS; l++)
      chk("dup_rs1_eq_rs2", alu_rs1[l*32 +: 32], alu_rs2[l*32 +: 32] ^ 32'd0 ? exp_lane(1, l) : 32'd0);
    finish_txn(0);

    // Randomized instructions.
    for (int t = 0; t < 20; t++) begin
      set_txn(8'($urandom()), 5'($urandom()), $urandom(), $urandom_range(0, 3),
              $urandom_range(0, NR - 1), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
              $urandom_range(0, NR - 1), $urandom(), $urandom_range(0, 100000));
      start_txn();
      finish_txn($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
